up_down_counter_mod: RTL

Parametrised up/down counter with configurable width, modulus bounds, step size and wrap-or-saturate mode. It adds enable, synchronous clear, parallel load, terminal-count flags and one-cycle overflow/underflow pulses. It is the general-purpose counting primitive for the design, used for timers, decade counters and position tracking, and it replaces fixed 8-bit free-running counters.

---
 rtl/up_down_counter_pkg.sv | 17 +
 rtl/up_down_counter_mod.sv | 118 +++++++++++
 2 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared constants and the parameter legality check for up_down_counter_mod.
package up_down_counter_pkg;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // True when the width, bounds and step describe a legal counter.
  function automatic bit params_ok(input int width, input longint min_val,
                                   input longint max_val, input longint step);
    longint top;
    top = (64'sd1 <<< width) - 64'sd1;
    return (width >= 32'sd2) && (width <= 32'sd32) &&
           (min_val >= 64'sd0) && (min_val < max_val) && (max_val <= top) &&
           (step >= 64'sd1) && (step <= max_val - min_val + 64'sd1);
  endfunction

endpackage

// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter: bounded range, configurable step, wrap or
// saturate at the bounds, with load, clear, terminal flags and cross pulses.
module up_down_counter_mod
  import up_down_counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MIN_VAL  = 64'sd0,
  parameter longint MAX_VAL  = (64'sd1 <<< WIDTH) - 64'sd1,
  parameter longint STEP     = 64'sd1,
  parameter bit     SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_min,
  output logic             overflow,
  output logic             underflow
);

  if (!params_ok(WIDTH, MIN_VAL, MAX_VAL, STEP)) begin : g_param_error
    $error("up_down_counter_mod: illegal WIDTH/MIN_VAL/MAX_VAL/STEP combination");
  end

  // Two guard bits: one for the up-sum carry, one as sign for the down-difference.
  localparam longint           RANGE_L = MAX_VAL - MIN_VAL + 64'sd1;
  localparam logic [WIDTH+1:0] MIN_X   = MIN_VAL[WIDTH+1:0];
  localparam logic [WIDTH+1:0] MAX_X   = MAX_VAL[WIDTH+1:0];
  localparam logic [WIDTH+1:0] STEP_X  = STEP[WIDTH+1:0];
  localparam logic [WIDTH+1:0] RANGE_X = RANGE_L[WIDTH+1:0];
  localparam logic [WIDTH-1:0] MIN_W   = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_W   = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0]        cnt_r;
  logic                    ovf_r;
  logic                    unf_r;
  logic [WIDTH-1:0]        next_cnt_s;
  logic                    next_ovf_s;
  logic                    next_unf_s;
  logic [WIDTH+1:0]        cnt_x_s;
  logic [WIDTH+1:0]        sum_s;
  logic signed [WIDTH+1:0] diff_s;

  assign cnt_x_s = {2'b00, cnt_r};
  assign sum_s   = cnt_x_s + STEP_X;
  assign diff_s  = $signed(cnt_x_s - STEP_X);

  // Next count and crossing pulses; priority clear > load > enable > hold.
  always_comb begin
    next_cnt_s = cnt_r;
    next_ovf_s = 1'b0;
    next_unf_s = 1'b0;
    if (clear) begin
      next_cnt_s = MIN_W;
    end else if (load) begin
      if (load_value > MAX_W) begin
        next_cnt_s = MAX_W;
      end else if (load_value < MIN_W) begin
        next_cnt_s = MIN_W;
      end else begin
        next_cnt_s = load_value;
      end
    end else if (enable) begin
      if (up_down) begin
        if (sum_s > MAX_X) begin
          if (SATURATE == MODE_SAT) begin
            next_cnt_s = MAX_W;
            next_ovf_s = (cnt_r != MAX_W);
          end else begin
            next_cnt_s = WIDTH'(sum_s - RANGE_X);
            next_ovf_s = 1'b1;
          end
        end else begin
          next_cnt_s = WIDTH'(sum_s);
        end
      end else begin
        if (diff_s < $signed(MIN_X)) begin
          if (SATURATE == MODE_SAT) begin
            next_cnt_s = MIN_W;
            next_unf_s = (cnt_r != MIN_W);
          end else begin
            next_cnt_s = WIDTH'(cnt_x_s - STEP_X + RANGE_X);
            next_unf_s = 1'b1;
          end
        end else begin
          next_cnt_s = WIDTH'(diff_s);
        end
      end
    end else begin
      next_cnt_s = cnt_r;
    end
  end

  // Single register stage; reset forces the bottom of the range immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= MIN_W;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      cnt_r <= next_cnt_s;
      ovf_r <= next_ovf_s;
      unf_r <= next_unf_s;
    end
  end

  assign out       = cnt_r;
  assign at_max    = (cnt_r == MAX_W);
  assign at_min    = (cnt_r == MIN_W);
  assign overflow  = ovf_r;
  assign underflow = unf_r;

endmodule
